// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: table entry layout,
// counter init/limit values and the lookup/update index hash.
package bp_pkg;

  // Entry fields are sized for RV32 and the widest supported counter.
  localparam int unsigned BpXlen       = 32;
  localparam int unsigned BpCtrMaxBits = 4;

  typedef struct packed {
    logic                    valid;
    logic [BpXlen-3:0]       tag;
    logic [BpXlen-1:0]       target;
    logic [BpCtrMaxBits-1:0] ctr;
  } bp_entry_t;

  // Weakly not-taken: 2^(n-1)-1
  function automatic logic [BpCtrMaxBits-1:0] ctr_init_nt(int unsigned ctr_bits);
    return BpCtrMaxBits'((32'd1 << (ctr_bits - 1)) - 32'd1);
  endfunction

  // Weakly taken: 2^(n-1)
  function automatic logic [BpCtrMaxBits-1:0] ctr_init_t(int unsigned ctr_bits);
    return BpCtrMaxBits'(32'd1 << (ctr_bits - 1));
  endfunction

  // Strongly taken: 2^n-1
  function automatic logic [BpCtrMaxBits-1:0] ctr_max(int unsigned ctr_bits);
    return BpCtrMaxBits'((32'd1 << ctr_bits) - 32'd1);
  endfunction

  // Word-index bits of the PC, XORed with zero-padded global history.
  function automatic logic [31:0] idx_hash(logic [31:0] pc, logic [31:0] ghr,
                                           int unsigned idx_bits);
    return ((pc >> 2) ^ ghr) & ((32'd1 << idx_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch lookup / decode training bundle for the branch predictor.
interface branch_predictor_if #(
  parameter int unsigned XLEN = 32
) ();
  logic [XLEN-1:0] pc_f;
  logic            pred_hit_f;
  logic            pred_taken_f;
  logic [XLEN-1:0] pred_target_f;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_is_jump;
  logic            upd_mispredict;
  logic [31:0]     stat_updates;
  logic [31:0]     stat_mispredicts;

  modport master (
    output pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict,
    input  pred_hit_f, pred_taken_f, pred_target_f, stat_updates, stat_mispredicts
  );

  modport slave (
    input  pc_f, upd_valid, upd_pc, upd_taken, upd_target, upd_is_jump, upd_mispredict,
    output pred_hit_f, pred_taken_f, pred_target_f, stat_updates, stat_mispredicts
  );
endinterface

// File: rtl/bp_sat_counter.sv
// Saturating up/down next-value logic for a direction counter.
module bp_sat_counter #(
  parameter int unsigned CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] i_ctr,
  input  logic                i_inc,
  output logic [CTR_BITS-1:0] o_ctr
);
  // Step toward the outcome, holding at either end of the range
  always_comb begin
    o_ctr = i_ctr;
    if (i_inc) begin
      if (i_ctr != '1) o_ctr = i_ctr + 1'b1;
    end else begin
      if (i_ctr != '0) o_ctr = i_ctr - 1'b1;
    end
  end
endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped dynamic branch predictor: combinational fetch lookup,
// one-cycle training from the decode-stage control hazard unit, optional
// gshare indexing (GHR_BITS > 0). Define BP_STATS_EN to compile in the
// saturating update/mispredict statistics counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ENTRIES  = 64,
  parameter int unsigned CTR_BITS = 2,
  parameter int unsigned GHR_BITS = 0
) (
  input logic          clk,
  input logic          reset,
  branch_predictor_if.slave bp
);
  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned GHR_W    = (GHR_BITS > 0) ? GHR_BITS : 1;

  bp_entry_t            r_table [ENTRIES];
  logic [GHR_W-1:0]     r_ghr;
  logic [31:0]          w_ghr_ext;
  logic [IDX_BITS-1:0]  w_lk_idx;
  logic [IDX_BITS-1:0]  w_up_idx;
  bp_entry_t            w_lk;
  bp_entry_t            w_up;
  bp_entry_t            w_new;
  logic                 w_up_hit;
  logic                 w_we;
  logic [CTR_BITS-1:0]  w_ctr_next;
  logic                 w_unused_bits;

  assign w_ghr_ext = (GHR_BITS > 0) ? 32'(r_ghr) : 32'd0;
  assign w_lk_idx  = IDX_BITS'(idx_hash(32'(bp.pc_f), w_ghr_ext, IDX_BITS));
  assign w_up_idx  = IDX_BITS'(idx_hash(32'(bp.upd_pc), w_ghr_ext, IDX_BITS));
  assign w_lk      = r_table[w_lk_idx];
  assign w_up      = r_table[w_up_idx];

  // Lookup reads pre-update state; no bypass from the update port.
  assign bp.pred_hit_f    = w_lk.valid && (w_lk.tag == bp.pc_f[XLEN-1:2]);
  assign bp.pred_taken_f  = bp.pred_hit_f && w_lk.ctr[CTR_BITS-1];
  assign bp.pred_target_f = bp.pred_hit_f ? w_lk.target : '0;

  assign w_up_hit = w_up.valid && (w_up.tag == bp.upd_pc[XLEN-1:2]);

  // Counter bits above CTR_BITS are never looked at
  assign w_unused_bits = ^{w_lk.ctr, w_up.ctr};

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .i_ctr (w_up.ctr[CTR_BITS-1:0]),
    .i_inc (bp.upd_taken),
    .o_ctr (w_ctr_next)
  );

  // Build the replacement entry and decide whether the table is written
  always_comb begin
    w_new = w_up;
    w_we  = 1'b0;
    if (w_up_hit) begin
      w_we = 1'b1;
      if (bp.upd_is_jump) begin
        w_new.ctr    = ctr_max(CTR_BITS);
        w_new.target = bp.upd_target;
      end else begin
        w_new.ctr                 = '0;
        w_new.ctr[CTR_BITS-1:0]   = w_ctr_next;
        if (bp.upd_taken) w_new.target = bp.upd_target;
      end
    end else if (bp.upd_taken || bp.upd_is_jump) begin
      // Allocate, evicting whatever aliased into this slot
      w_we         = 1'b1;
      w_new.valid  = 1'b1;
      w_new.tag    = bp.upd_pc[XLEN-1:2];
      w_new.target = bp.upd_target;
      w_new.ctr    = bp.upd_is_jump ? ctr_max(CTR_BITS) : ctr_init_t(CTR_BITS);
    end
  end

  // Table and history state; reset wins over a same-cycle update
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_table[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: ctr_init_nt(CTR_BITS)};
      end
      r_ghr <= '0;
    end else if (bp.upd_valid) begin
      if (w_we) r_table[w_up_idx] <= w_new;
      if (GHR_BITS > 0 && !bp.upd_is_jump) r_ghr <= GHR_W'({r_ghr, bp.upd_taken});
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] r_stat_upd;
  logic [31:0] r_stat_mis;

  // Saturating counters of accepted updates and reported mispredicts
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_upd <= '0;
      r_stat_mis <= '0;
    end else if (bp.upd_valid) begin
      if (r_stat_upd != '1) r_stat_upd <= r_stat_upd + 32'd1;
      if (bp.upd_mispredict && r_stat_mis != '1) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign bp.stat_updates     = r_stat_upd;
  assign bp.stat_mispredicts = r_stat_mis;
`else
  logic w_unused_mispredict;
  assign w_unused_mispredict = bp.upd_mispredict;
  assign bp.stat_updates     = '0;
  assign bp.stat_mispredicts = '0;
`endif

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor for the fetch stage of the 5-stage RV32I pipeline. It holds a direct-mapped table of saturating direction counters plus branch-target entries. Fetch looks the table up combinationally, so a predicted-taken branch or jump redirects the PC without waiting for decode-stage resolution. The decode-stage control hazard unit trains the table with resolved outcomes; an optional global-history mode (gshare) is selected by parameter.

## Interface

- XLEN, 32: address/data width.
- ENTRIES, 64: table depth; power of two, ≥4. IDX_BITS = log2(ENTRIES).
- CTR_BITS, 2: direction counter width, 1..4.
- GHR_BITS, 0: global history length; 0 = bimodal, else ≤ IDX_BITS.

- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- pc_f  in  XLEN  fetch PC being looked up.
- pred_hit_f  out  1  valid entry with matching tag.
- pred_taken_f  out  1  hit and counter MSB = 1.
- pred_target_f  out  XLEN  stored target when hit, else 0.
- upd_valid  in  1  resolved control-flow instruction this cycle.
- upd_pc  in  XLEN  PC of resolved instruction.
- upd_taken  in  1  actual outcome.
- upd_target  in  XLEN  actual target.
- upd_is_jump  in  1  JAL/JALR (unconditional).
- upd_mispredict  in  1  CHU detected wrong prediction; used only by statistics.
- stat_updates  out  32  number of accepted updates (only with BP_STATS_EN).
- stat_mispredicts  out  32  number of mispredicts (only with BP_STATS_EN).

## Operation

- Entry fields: valid, tag = pc[XLEN-1:2], target[XLEN-1:0], ctr[CTR_BITS-1:0].
- Index: pc[IDX_BITS+1:2] when GHR_BITS = 0. Otherwise the same bits XOR {zero-pad, ghr}.
- Lookup is combinational. Hit = valid && tag == pc_f[XLEN-1:2]. Outputs are 0 on miss.
- Update (upd_valid = 1), at the upd_pc index:
  - Hit, conditional branch: ctr +1 if taken, −1 if not; saturates at 0 and 2^CTR_BITS−1. Target is overwritten when taken.
  - Hit, jump: ctr := max; target := upd_target.
  - Miss, taken or jump: allocate. valid=1, tag, target written. ctr := 2^(CTR_BITS−1) (weakly taken), or max for a jump. Any aliasing entry is evicted.
  - Miss, not taken, not jump: no table write.
- GHR (GHR_BITS > 0): on every update of a conditional branch, ghr := {ghr[GHR_BITS-2:0], upd_taken}. Jumps do not shift the GHR. Both lookup and update use the current GHR, with no speculative history.
- Reset: all valid := 0, all ctr := 2^(CTR_BITS−1)−1 (weakly not-taken), targets/tags := 0, ghr := 0. Completes in the single reset cycle.

## Timing

- Lookup latency is 0 cycles, combinational from pc_f and state.
- Update latency is 1 cycle; the new state is visible to lookups from the next cycle.
- A lookup and an update to the same index in the same cycle return the pre-update contents. There is no bypass.
- Reset asserted alongside upd_valid: reset wins and the update is dropped.
- Output reset values: pred_hit_f = 0, pred_taken_f = 0, pred_target_f = 0 for any pc_f. Stat outputs = 0.
- The block has no stall input. The fetch stage holds pc_f steady while StallF is asserted, and the outputs stay stable with it.

## Configuration

- BP_STATS_EN defined: two 32-bit counters are compiled in.
  - stat_updates +1 per upd_valid.
  - stat_mispredicts +1 per upd_valid && upd_mispredict.
  - Both saturate at 0xFFFF_FFFF and clear on reset.
- Undefined: the counters are absent, stat_* are tied to 0, and upd_mispredict is ignored.

## Structure

- Package bp_pkg holds:
  - the entry struct typedef (valid, tag, target, ctr);
  - functions ctr_init_nt / ctr_init_t / ctr_max(CTR_BITS);
  - the index-hash function.
- Sub-module bp_sat_counter: CTR_BITS-wide saturating up/down next-value logic, instantiated once on the update path.
- The table is a flop array indexed by update and lookup ports. No RAM macro is used.

## Test plan

Cases 1–5 use ENTRIES=16, CTR_BITS=2, GHR_BITS=0.

1. After reset, lookup pc_f=0x100 -> hit 0, taken 0, target 0x0.
2. Update pc 0x100 taken target 0x80 -> next cycle, lookup 0x100 gives hit 1, taken 1 (ctr=2), target 0x80.
3. Then two not-taken updates at 0x100 -> ctr=0, hit 1, taken 0. A third not-taken update keeps ctr=0 (saturation).
4. Update pc 0x140 (same index 0) taken target 0x200 -> lookup 0x100 gives hit 0. Lookup 0x140 gives hit 1, target 0x200.
5. Jump update pc 0x10 target 0x300, then one not-taken update -> ctr=2, taken 1. The same-cycle lookup during the first update shows hit 0.
6. GHR_BITS=2, BP_STATS_EN defined: updates at pc 0x20 are taken, taken, not-taken with mispredict on the third -> ghr=2'b10, stat_updates=3, stat_mispredicts=1. Reset asserted -> both stats and ghr return to 0.
